// File: rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv - shared state and mode encodings for the ADC capture buffer
package ad_ip_jesd204_tpl_adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_TRIGGERED  = 1'b1;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_if.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_if.sv - sample input, DMA output and control/status bundle
interface ad_ip_jesd204_tpl_adc_capture_if #(
  parameter int NUM_CHANNELS        = 4,
  parameter int DATA_PATH_WIDTH     = 1,
  parameter int BITS_PER_SAMPLE     = 16,
  parameter int FIFO_ADDRESS_WIDTH  = 4,
  parameter int CAPTURE_COUNT_WIDTH = 16
);
  localparam int DATA_WIDTH = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE;

  logic [NUM_CHANNELS-1:0]        enable;
  logic                           in_valid;
  logic [DATA_WIDTH-1:0]          in_data;
  logic                           trigger;
  logic                           cfg_mode;
  logic [CAPTURE_COUNT_WIDTH-1:0] cfg_capture_len;
  logic                           cfg_arm;
  logic                           cfg_abort;
  logic                           cfg_ovf_clr;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           status_busy;
  logic                           status_done;
  logic                           status_ovf;
  logic [FIFO_ADDRESS_WIDTH:0]    fifo_level;

  modport master (
    output enable, in_valid, in_data, trigger, cfg_mode, cfg_capture_len,
           cfg_arm, cfg_abort, cfg_ovf_clr, out_ready,
    input  out_valid, out_data, status_busy, status_done, status_ovf, fifo_level
  );

  modport slave (
    input  enable, in_valid, in_data, trigger, cfg_mode, cfg_capture_len,
           cfg_arm, cfg_abort, cfg_ovf_clr, out_ready,
    output out_valid, out_data, status_busy, status_done, status_ovf, fifo_level
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv
// rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv - first-word-fall-through beat FIFO
module ad_ip_jesd204_tpl_adc_capture_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ADDRESS_WIDTH:0]  o_level
);

  logic [DATA_WIDTH-1:0]  r_mem [2**ADDRESS_WIDTH];
  logic [ADDRESS_WIDTH:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0] r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Push into a full FIFO is only issued alongside a pop, so it lands in the slot being vacated.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[ADDRESS_WIDTH-1:0]] <= i_data;
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_level == '0);
  assign o_full  = o_level[ADDRESS_WIDTH];
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0]];

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// rtl/ad_ip_jesd204_tpl_adc_capture.sv - triggered/continuous capture buffer between TPL ADC and DMA
module ad_ip_jesd204_tpl_adc_capture
  import ad_ip_jesd204_tpl_adc_capture_pkg::*;
#(
  parameter int NUM_CHANNELS        = 4,
  parameter int DATA_PATH_WIDTH     = 1,
  parameter int BITS_PER_SAMPLE     = 16,
  parameter int FIFO_ADDRESS_WIDTH  = 4,
  parameter int CAPTURE_COUNT_WIDTH = 16
) (
  input logic                             i_clk,
  input logic                             i_rst_n,
  ad_ip_jesd204_tpl_adc_capture_if.slave  io_cap
);

  localparam int SLICE_W    = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam int DATA_WIDTH = NUM_CHANNELS * SLICE_W;

  logic [1:0]                     r_rst_sync;
  logic                           w_rst_n;
  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CAPTURE_COUNT_WIDTH-1:0] r_len;
  logic [CAPTURE_COUNT_WIDTH-1:0] r_cnt;
  logic                           r_ovf;
  logic                           r_done;
  logic                           w_beat;
  logic                           w_trig_beat;
  logic                           w_cand;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_full;
  logic                           w_empty;
  logic [DATA_WIDTH-1:0]          w_data_masked;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_beat      = io_cap.in_valid && (|io_cap.enable);
  assign w_trig_beat = w_beat && io_cap.trigger;
  assign w_cand      = w_beat && ((r_state == ST_STREAM) || (r_state == ST_CAPTURE) ||
                                  ((r_state == ST_ARMED) && io_cap.trigger && !io_cap.cfg_abort));
  assign w_pop       = !w_empty && io_cap.out_ready;
  assign w_push      = w_cand && (!w_full || w_pop);

  always_comb begin
    w_data_masked = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (io_cap.enable[c]) w_data_masked[c*SLICE_W +: SLICE_W] = io_cap.in_data[c*SLICE_W +: SLICE_W];
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (io_cap.cfg_arm) begin
          unique case (io_cap.cfg_mode)
            MODE_TRIGGERED:  w_state_nxt = ST_ARMED;
            MODE_CONTINUOUS: w_state_nxt = ST_STREAM;
            default:         w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_STREAM: if (io_cap.cfg_abort) w_state_nxt = ST_DRAIN;
      ST_ARMED: begin
        if (io_cap.cfg_abort)  w_state_nxt = ST_IDLE;
        else if (w_trig_beat)  w_state_nxt = (r_len == '0) ? ST_DRAIN : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (io_cap.cfg_abort || (w_beat && (r_cnt == r_len))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_empty) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The trigger beat is beat 0, so the counter holds the index of the next beat to arrive.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (io_cap.cfg_arm) begin
          r_len <= io_cap.cfg_capture_len;
          r_cnt <= '0;
        end
        ST_ARMED:   if (w_trig_beat) r_cnt <= CAPTURE_COUNT_WIDTH'(1);
        ST_CAPTURE: if (w_beat)      r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_cand && w_full && !w_pop) r_ovf <= 1'b1;
      else if (io_cap.cfg_ovf_clr)    r_ovf <= 1'b0;
      r_done <= (r_state == ST_DRAIN) && w_empty;
    end
  end

  ad_ip_jesd204_tpl_adc_capture_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (FIFO_ADDRESS_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_data  (w_data_masked),
    .i_pop   (w_pop),
    .o_data  (io_cap.out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (io_cap.fifo_level)
  );

  assign io_cap.out_valid   = !w_empty;
  assign io_cap.status_busy = (r_state != ST_IDLE);
  assign io_cap.status_done = r_done;
  assign io_cap.status_ovf  = r_ovf;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// tb/tb_ad_ip_jesd204_tpl_adc_capture.sv - randomized bench against a queue-based capture model
module tb_ad_ip_jesd204_tpl_adc_capture;

  localparam int NC    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_adc_capture_if #(
    .NUM_CHANNELS(NC), .DATA_PATH_WIDTH(1), .BITS_PER_SAMPLE(16),
    .FIFO_ADDRESS_WIDTH(4), .CAPTURE_COUNT_WIDTH(16)
  ) cap ();

  ad_ip_jesd204_tpl_adc_capture #(
    .NUM_CHANNELS(NC), .DATA_PATH_WIDTH(1), .BITS_PER_SAMPLE(16),
    .FIFO_ADDRESS_WIDTH(4), .CAPTURE_COUNT_WIDTH(16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_cap  (cap)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected FIFO contents plus a description of what the capture is doing.
  logic [63:0] m_q[$];
  bit          m_stream, m_armed, m_capturing, m_draining;
  int          m_left, m_len;
  bit          m_ovf, m_done;
  logic [7:0]  m_seq;

  logic [63:0] dut_out[$];
  int          dut_done_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_stream = 0; m_armed = 0; m_capturing = 0; m_draining = 0;
    m_left = 0; m_len = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    check_val("out_valid", cap.out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check_val("out_data", cap.out_data, m_q[0]);
    check_val("fifo_level", cap.fifo_level, m_q.size());
    check_val("status_busy", cap.status_busy, m_stream | m_armed | m_capturing | m_draining);
    check_val("status_done", cap.status_done, m_done);
    check_val("status_ovf", cap.status_ovf, m_ovf);
  endtask

  task automatic model_step(input bit arm, input bit mode, input int len, input bit abort,
                            input bit clr, input logic [3:0] en, input bit iv, input bit trig,
                            input bit ready, input logic [63:0] data);
    logic [63:0] md;
    bit pop, beat, wr, ovf_set, done_n, idle;
    md = '0;
    for (int c = 0; c < NC; c++) if (en[c]) md[c*16 +: 16] = data[c*16 +: 16];
    pop     = (m_q.size() > 0) && ready;
    beat    = iv && (en != 0);
    wr      = beat && (m_stream || m_capturing || (m_armed && trig && !abort));
    ovf_set = wr && (m_q.size() == DEPTH) && !pop;
    done_n  = m_draining && (m_q.size() == 0);
    idle    = !(m_stream || m_armed || m_capturing || m_draining);
    if (idle) begin
      if (arm) begin
        if (mode) begin m_armed = 1; m_len = len; end
        else m_stream = 1;
      end
    end else if (m_stream) begin
      if (abort) begin m_stream = 0; m_draining = 1; end
    end else if (m_armed) begin
      if (abort) m_armed = 0;
      else if (beat && trig) begin
        m_armed = 0;
        if (m_len == 0) m_draining = 1;
        else begin m_capturing = 1; m_left = m_len; end
      end
    end else if (m_capturing) begin
      if (beat) m_left--;
      if (abort || (beat && m_left == 0)) begin m_capturing = 0; m_draining = 1; end
    end else if (m_draining) begin
      if (m_q.size() == 0) m_draining = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (wr && !ovf_set) m_q.push_back(md);
    m_ovf  = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_done = done_n;
  endtask

  task automatic cycle(input bit arm, input bit mode, input int len, input bit abort,
                       input bit clr, input logic [3:0] en, input bit iv, input bit trig,
                       input bit ready);
    logic [63:0] data;
    @(negedge clk);
    check_outputs();
    if (cap.status_done) dut_done_cnt++;
    data = {$urandom, $urandom};
    data[7:0] = m_seq;
    cap.cfg_arm = arm; cap.cfg_mode = mode; cap.cfg_capture_len = 16'(len);
    cap.cfg_abort = abort; cap.cfg_ovf_clr = clr; cap.enable = en;
    cap.in_valid = iv; cap.trigger = trig; cap.out_ready = ready; cap.in_data = data;
    if (cap.out_valid && ready) dut_out.push_back(cap.out_data);
    model_step(arm, mode, len, abort, clr, en, iv, trig, ready, data);
    if (iv) m_seq++;
  endtask

  task automatic idle_cycles(input int n, input bit ready);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 4'hF, 0, 0, ready);
  endtask

  int p0, d0;
  logic [63:0] w;

  initial begin
    model_clear();
    m_seq = 0; dut_done_cnt = 0;
    cap.cfg_arm = 0; cap.cfg_mode = 0; cap.cfg_capture_len = 0; cap.cfg_abort = 0;
    cap.cfg_ovf_clr = 0; cap.enable = 4'hF; cap.in_valid = 0; cap.trigger = 0;
    cap.out_ready = 0; cap.in_data = '0;

    #12;
    check_val("rst_out_valid", cap.out_valid, 1'b0);
    check_val("rst_out_data", cap.out_data, 64'h0);
    check_val("rst_level", cap.fifo_level, 5'd0);
    check_val("rst_busy", cap.status_busy, 1'b0);
    check_val("rst_done", cap.status_done, 1'b0);
    check_val("rst_ovf", cap.status_ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(3, 1);

    // Continuous stream of 100 beats then abort.
    p0 = dut_out.size(); d0 = dut_done_cnt;
    cycle(1, 0, 0, 0, 0, 4'hF, 0, 0, 1);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0, 0, 4'hF, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 4'hF, 0, 0, 1);
    idle_cycles(6, 1);
    check_val("t1_beats", dut_out.size() - p0, 100);
    check_val("t1_done_pulses", dut_done_cnt - d0, 1);
    check_val("t1_ovf", cap.status_ovf, 1'b0);

    // Triggered capture of 8 beats starting at sequence 0x0A.
    m_seq = 0; p0 = dut_out.size(); d0 = dut_done_cnt;
    cycle(1, 1, 7, 0, 0, 4'hF, 0, 0, 1);
    for (int i = 0; i < 25; i++) cycle(0, 0, 3, 0, 0, 4'hF, 1, m_seq == 8'h0A, 1);
    idle_cycles(5, 1);
    check_val("t2_beats", dut_out.size() - p0, 8);
    check_val("t2_done_pulses", dut_done_cnt - d0, 1);
    if (dut_out.size() - p0 == 8) begin
      w = dut_out[p0];     check_val("t2_first", w[7:0], 8'h0A);
      w = dut_out[p0 + 7]; check_val("t2_last", w[7:0], 8'h11);
    end
    check_val("t2_busy_after", cap.status_busy, 1'b0);

    // Overflow with no DMA accept, then clear, then full with simultaneous pop.
    m_seq = 0; p0 = dut_out.size();
    cycle(1, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 4'hF, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    check_val("t3_level", cap.fifo_level, 5'd16);
    check_val("t3_ovf", cap.status_ovf, 1'b1);
    cycle(0, 0, 0, 0, 1, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    check_val("t3_ovf_clr", cap.status_ovf, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 4'hF, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 4'hF, 0, 0, 0);
    check_val("t4_level", cap.fifo_level, 5'd16);
    check_val("t4_ovf", cap.status_ovf, 1'b0);
    idle_cycles(20, 1);
    if (dut_out.size() > p0) begin w = dut_out[p0]; check_val("t3_first_kept", w[7:0], 8'h00); end

    // Channel masking, then abort while armed.
    cycle(1, 0, 0, 0, 0, 4'b0101, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 4'b0101, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 4'b0101, 0, 0, 1);
    idle_cycles(4, 1);
    w = dut_out[dut_out.size() - 1];
    check_val("t5_mask", w & 64'hFFFF_0000_FFFF_0000, 64'h0);
    p0 = dut_out.size(); d0 = dut_done_cnt;
    cycle(1, 1, 4, 0, 0, 4'hF, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 4'hF, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 4'hF, 1, 1, 1);
    idle_cycles(4, 1);
    check_val("t5_abort_writes", dut_out.size() - p0, 0);
    check_val("t5_abort_done", dut_done_cnt - d0, 0);

    // Reset while capturing with 5 beats queued.
    cycle(1, 1, 30, 0, 0, 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 4'hF, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 4'hF, 1, 0, 0);
    @(posedge clk); #2;
    check_val("t6_pre_level", cap.fifo_level, 5'd5);
    rst_n = 1'b0; #1;
    check_val("t6_out_valid", cap.out_valid, 1'b0);
    check_val("t6_busy", cap.status_busy, 1'b0);
    check_val("t6_level", cap.fifo_level, 5'd0);
    model_clear();
    idle_cycles(2, 0);
    rst_n = 1'b1;
    idle_cycles(3, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] en;
      en = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
      cycle($urandom % 20 == 0, 1'($urandom), $urandom % 12, $urandom % 40 == 0,
            $urandom % 30 == 0, en, $urandom % 4 != 0, $urandom % 6 == 0, $urandom % 3 != 0);
    end
    idle_cycles(2, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_capture.md
Name: ad_ip_jesd204_tpl_adc_capture

Overview:
Triggered or continuous capture buffer between the TPL ADC core sample output and the DMA.
- Adds what the plain TPL ADC path lacks: a back-pressurable output, a finite-length triggered capture, and a sticky overflow indicator.
- Sits in the link_clk domain, directly downstream of the deframer/data-format core.

Parameters:
NUM_CHANNELS, 4, converter channels.
DATA_PATH_WIDTH, 1, samples per channel per beat.
BITS_PER_SAMPLE, 16, bits per sample slot.
FIFO_ADDRESS_WIDTH, 4, log2 of FIFO depth (depth 16 beats).
CAPTURE_COUNT_WIDTH, 16, width of capture length counter.
Derived: DATA_WIDTH = NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE.

Ports:
clk  in  1  link clock (line-rate/40).
resetn  in  1  asynchronous active-low reset.
enable  in  NUM_CHANNELS  per-channel enable from the regmap.
in_valid  in  1  input beat valid; never back-pressured.
in_data  in  DATA_WIDTH  channel-major sample data.
trigger  in  1  capture trigger, sampled with in_valid.
cfg_mode  in  1  0 = continuous, 1 = triggered; sampled on arm.
cfg_capture_len  in  CAPTURE_COUNT_WIDTH  beats to capture minus 1.
cfg_arm  in  1  single-cycle arm pulse.
cfg_abort  in  1  single-cycle abort pulse.
cfg_ovf_clr  in  1  clears status_ovf.
out_valid  out  1  output beat valid.
out_ready  in  1  DMA accept.
out_data  out  DATA_WIDTH  output beat.
status_busy  out  1  state != IDLE.
status_done  out  1  one-cycle pulse on return to IDLE from DRAIN.
status_ovf  out  1  sticky overflow.
fifo_level  out  FIFO_ADDRESS_WIDTH+1  occupied entries.

Behaviour:
Reset (async assert, sync deassert internally):
- state IDLE, FIFO empty, fifo_level 0.
- out_valid 0, out_data 0.
- status_busy/done/ovf all 0; mode latch 0; counter 0.

Write rule:
- A beat is a write candidate when in_valid and |enable and state is STREAM, CAPTURE, or ARMED-with-trigger.
- Slices of disabled channels are zeroed before the write.

FIFO:
- First-word-fall-through, depth 2^FIFO_ADDRESS_WIDTH.
- A beat written in cycle t appears on out_data with out_valid in cycle t+1.
- A pop occurs when out_valid and out_ready.
- Full with a write candidate:
  - If a pop occurs in the same cycle, the write succeeds.
  - Otherwise the beat is dropped and status_ovf is set.
- status_ovf is cleared by cfg_ovf_clr. If set and clear coincide in the same cycle, set wins.

FSM:
- IDLE:
  - cfg_arm with cfg_mode=0 -> STREAM.
  - cfg_arm with cfg_mode=1 -> ARMED, counter cleared.
- STREAM: write every candidate; cfg_abort -> DRAIN.
- ARMED:
  - First cycle with in_valid and trigger: that beat is capture beat 0 -> CAPTURE.
  - If cfg_capture_len=0, go -> DRAIN instead.
  - cfg_abort -> IDLE; no done pulse.
- CAPTURE:
  - Each in_valid beat increments the counter. Dropped beats still count, so the capture window is time-accurate.
  - On the beat where counter == cfg_capture_len -> DRAIN.
  - cfg_abort -> DRAIN.
- DRAIN: no writes; when the FIFO is empty -> IDLE and pulse status_done.

Other rules:
- cfg_arm outside IDLE is ignored.
- cfg_capture_len and cfg_mode are latched at arm; later changes have no effect until the next arm.
- Abort and the terminal-count beat in the same cycle: the beat is written, then -> DRAIN.
- enable change mid-capture takes effect on the next beat; a beat with all channels disabled is neither written nor counted.
- out_data holds its value while out_valid && !out_ready.

Decomposition:
- Shared package ad_ip_jesd204_tpl_adc_capture_pkg holds:
  - state encodings IDLE/STREAM/ARMED/CAPTURE/DRAIN;
  - mode constants MODE_CONTINUOUS = 0, MODE_TRIGGERED = 1.
- One sub-module, ad_ip_jesd204_tpl_adc_capture_fifo:
  - synchronous FWFT FIFO, async active-low reset;
  - parameters DATA_WIDTH and ADDRESS_WIDTH;
  - ports: push/pop, full, empty, level.

Test Plan:
1. Continuous stream:
   - Stimulus: NUM_CHANNELS=4, enable=4'b1111, arm with mode 0, in_valid every cycle for 100 beats, out_ready=1, then abort.
   - Required: 100 beats out in order, each 1 cycle after input; status_done pulses once the FIFO empties; status_ovf = 0.
2. Triggered capture:
   - Stimulus: cfg_capture_len=7, mode 1; trigger on the beat with data 0x..0A.
   - Required: exactly 8 beats out, 0x..0A to 0x..11; busy falls after the last pop; done pulses once.
3. Overflow:
   - Stimulus: FIFO_ADDRESS_WIDTH=4, out_ready=0, stream 20 beats.
   - Required: fifo_level saturates at 16; status_ovf = 1; first 16 beats retained.
   - Then cfg_ovf_clr -> status_ovf = 0.
4. Full plus simultaneous pop:
   - Stimulus: FIFO full, out_ready=1 and in_valid together.
   - Required: no overflow; level stays 16.
5. Channel masking and abort:
   - Stimulus: enable=4'b0101; then abort in ARMED.
   - Required: slices for channels 1 and 3 read 0; the ARMED abort returns to IDLE with no done pulse and no writes.
6. Reset mid-capture:
   - Stimulus: assert resetn=0 during CAPTURE with 5 beats in the FIFO.
   - Required: out_valid, busy, and level drop to 0 immediately, before any clock edge.
